// File: rtl/bc_pkg.sv
// bc_pkg: shared definitions for the bulls/cows judge.
//   - bc_state_t : FSM state encoding (GEN/IDLE/CHECK/SCORE/STORE/WIN/LOSE)
//   - LFSR_TAPS  : Galois tap mask for x^16+x^14+x^13+x^11
//   - field widths of a history entry (digit 4, bull 2, cow 2)
//   - helpers: lfsr_next (one LFSR step), digits_valid (BCD + distinct check)
package bc_pkg;

  typedef enum logic [2:0] {
    ST_GEN   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_CHECK = 3'd2,
    ST_SCORE = 3'd3,
    ST_STORE = 3'd4,
    ST_WIN   = 3'd5,
    ST_LOSE  = 3'd6
  } bc_state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int DIGIT_W = 4;
  localparam int BULL_W  = 2;
  localparam int COW_W   = 2;
  localparam int NUM_W   = 3 * DIGIT_W;
  localparam int HIST_N  = 8;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  // Right-shifting Galois step: the bit shifted out selects the tap mask.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic [15:0] shifted;
    shifted = {1'b0, l[15:1]};
    return l[0] ? (shifted ^ LFSR_TAPS) : shifted;
  endfunction

  // True when all three digits are decimal and pairwise distinct.
  function automatic logic digits_valid(input logic [NUM_W-1:0] n);
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    a = n[11:8];
    b = n[7:4];
    c = n[3:0];
    return (a <= DIGIT_MAX) && (b <= DIGIT_MAX) && (c <= DIGIT_MAX) &&
           (a != b) && (a != c) && (b != c);
  endfunction

endpackage

// File: rtl/bc_judge_score.sv
// bc_score: combinational bulls/cows counter over two 3-digit BCD triples.
// Ports:
//   i_guess  [11:0] {g1,g2,g3}
//   i_secret [11:0] {s1,s2,s3}
//   o_bull   [1:0]  positions where guess and secret digits match
//   o_cow    [1:0]  guess digits found in the secret at a different position
// Results saturate at 3; with distinct digits on both sides they never exceed it.
module bc_score
  import bc_pkg::*;
(
  input  logic [NUM_W-1:0]  i_guess,
  input  logic [NUM_W-1:0]  i_secret,
  output logic [BULL_W-1:0] o_bull,
  output logic [COW_W-1:0]  o_cow
);

  logic [3:0] w_bull_cnt;
  logic [3:0] w_cow_cnt;

  // Compare every guess digit with every secret digit; diagonal hits are bulls.
  always_comb begin
    w_bull_cnt = 4'd0;
    w_cow_cnt  = 4'd0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (i_guess[4*(2-i) +: 4] == i_secret[4*(2-j) +: 4]) begin
          if (i == j) begin
            w_bull_cnt = w_bull_cnt + 4'd1;
          end else begin
            w_cow_cnt = w_cow_cnt + 4'd1;
          end
        end else begin
          w_bull_cnt = w_bull_cnt;
        end
      end
    end
  end

  // Saturate to the 2-bit result fields.
  always_comb begin
    if (w_bull_cnt > 4'd3) begin
      o_bull = 2'd3;
    end else begin
      o_bull = w_bull_cnt[1:0];
    end
    if (w_cow_cnt > 4'd3) begin
      o_cow = 2'd3;
    end else begin
      o_cow = w_cow_cnt[1:0];
    end
  end

endmodule

// File: rtl/bc_judge.sv
// bc_judge: bulls/cows game judge fed by the keyboard controller.
// Draws a secret 3-digit number (distinct decimal digits) from a 16-bit LFSR,
// scores each guess, keeps a per-try history and tracks win/lose.
// Ports:
//   clk, reset (sync, active high)
//   iNum1..iNum3 [3:0] guess digits, iNumRdy one-cycle guess strobe
//   iNewGame           abandon the game and draw a new secret
//   iRdAddr [2:0]      history read select -> oRdNum/oRdBull/oRdCow (combinational)
//   oTries [3:0]       entries written this game
//   oResultVld, oReject one-cycle pulses; oWin, oLose levels; oBusy = not IDLE
// Optional macro BC_DEBUG_EN adds iForceSecret/iForceLd (overwrite secret in IDLE)
// and oSecret (current secret, 0 while generating).
module bc_judge
  import bc_pkg::*;
#(
  parameter int          MAX_TRIES = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  iNum1,
  input  logic [3:0]  iNum2,
  input  logic [3:0]  iNum3,
  input  logic        iNumRdy,
  input  logic        iNewGame,
  input  logic [2:0]  iRdAddr,
`ifdef BC_DEBUG_EN
  input  logic [11:0] iForceSecret,
  input  logic        iForceLd,
  output logic [11:0] oSecret,
`endif
  output logic [11:0] oRdNum,
  output logic [1:0]  oRdBull,
  output logic [1:0]  oRdCow,
  output logic [3:0]  oTries,
  output logic        oResultVld,
  output logic        oReject,
  output logic        oWin,
  output logic        oLose,
  output logic        oBusy
);

  bc_state_t r_state;
  bc_state_t w_state_nxt;

  logic [15:0]       r_lfsr;
  logic [NUM_W-1:0]  r_secret;
  logic [NUM_W-1:0]  r_guess;
  logic [BULL_W-1:0] r_bull;
  logic [COW_W-1:0]  r_cow;
  logic [3:0]        r_tries;
  logic [3:0]        w_tries_inc;
  logic              r_result_vld;
  logic              r_reject;
  logic              r_win;
  logic              r_lose;
  logic              r_busy;

  logic [NUM_W-1:0]  r_hist_num  [HIST_N];
  logic [BULL_W-1:0] r_hist_bull [HIST_N];
  logic [COW_W-1:0]  r_hist_cow  [HIST_N];

  logic [BULL_W-1:0] w_score_bull;
  logic [COW_W-1:0]  w_score_cow;
  logic              w_force_ld;
  logic [NUM_W-1:0]  w_force_val;

`ifdef BC_DEBUG_EN
  assign w_force_ld  = iForceLd;
  assign w_force_val = iForceSecret;
  assign oSecret     = (r_state == ST_GEN) ? 12'd0 : r_secret;
`else
  assign w_force_ld  = 1'b0;
  assign w_force_val = 12'd0;
`endif

  assign w_tries_inc = r_tries + 4'd1;

  bc_score u_score (
    .i_guess  (r_guess),
    .i_secret (r_secret),
    .o_bull   (w_score_bull),
    .o_cow    (w_score_cow)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_GEN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; iNewGame overrides everything, including guesses.
  always_comb begin
    w_state_nxt = r_state;
    if (iNewGame) begin
      w_state_nxt = ST_GEN;
    end else begin
      case (r_state)
        ST_GEN: begin
          if (digits_valid(r_lfsr[11:0])) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_GEN;
          end
        end
        ST_IDLE: begin
          if (iNumRdy) begin
            w_state_nxt = ST_CHECK;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_CHECK: begin
          if (digits_valid(r_guess)) begin
            w_state_nxt = ST_SCORE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_SCORE: w_state_nxt = ST_STORE;
        ST_STORE: begin
          // Outcome uses the try count after this entry is written.
          if (r_bull == 2'd3) begin
            w_state_nxt = ST_WIN;
          end else if (w_tries_inc == 4'(MAX_TRIES)) begin
            w_state_nxt = ST_LOSE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_WIN:  w_state_nxt = ST_WIN;
        ST_LOSE: w_state_nxt = ST_LOSE;
        default: w_state_nxt = ST_GEN;
      endcase
    end
  end

  // Datapath: LFSR, secret/guess latches, scoring, history and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr       <= LFSR_SEED;
      r_secret     <= 12'd0;
      r_guess      <= 12'd0;
      r_bull       <= 2'd0;
      r_cow        <= 2'd0;
      r_tries      <= 4'd0;
      r_result_vld <= 1'b0;
      r_reject     <= 1'b0;
      r_win        <= 1'b0;
      r_lose       <= 1'b0;
      r_busy       <= 1'b1;
      for (int i = 0; i < HIST_N; i++) begin
        r_hist_num[i]  <= 12'd0;
        r_hist_bull[i] <= 2'd0;
        r_hist_cow[i]  <= 2'd0;
      end
    end else begin
      r_lfsr       <= lfsr_next(r_lfsr);
      r_result_vld <= 1'b0;
      r_reject     <= 1'b0;
      r_busy       <= (w_state_nxt != ST_IDLE);
      if (iNewGame) begin
        // Abort whatever is in flight: no pulses, clean history.
        r_tries <= 4'd0;
        r_win   <= 1'b0;
        r_lose  <= 1'b0;
        for (int i = 0; i < HIST_N; i++) begin
          r_hist_num[i]  <= 12'd0;
          r_hist_bull[i] <= 2'd0;
          r_hist_cow[i]  <= 2'd0;
        end
      end else begin
        case (r_state)
          ST_GEN: begin
            if (digits_valid(r_lfsr[11:0])) begin
              r_secret <= r_lfsr[11:0];
            end
          end
          ST_IDLE: begin
            if (iNumRdy) begin
              r_guess <= {iNum1, iNum2, iNum3};
            end
            if (w_force_ld) begin
              r_secret <= w_force_val;
            end
          end
          ST_CHECK: begin
            if (!digits_valid(r_guess)) begin
              r_reject <= 1'b1;
            end
          end
          ST_SCORE: begin
            r_bull <= w_score_bull;
            r_cow  <= w_score_cow;
          end
          ST_STORE: begin
            r_hist_num[r_tries[2:0]]  <= r_guess;
            r_hist_bull[r_tries[2:0]] <= r_bull;
            r_hist_cow[r_tries[2:0]]  <= r_cow;
            r_tries      <= w_tries_inc;
            r_result_vld <= 1'b1;
            if (r_bull == 2'd3) begin
              r_win <= 1'b1;
            end else if (w_tries_inc == 4'(MAX_TRIES)) begin
              r_lose <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Combinational history read; entries beyond the written count read as 0.
  always_comb begin
    if ({1'b0, iRdAddr} < r_tries) begin
      oRdNum  = r_hist_num[iRdAddr];
      oRdBull = r_hist_bull[iRdAddr];
      oRdCow  = r_hist_cow[iRdAddr];
    end else begin
      oRdNum  = 12'd0;
      oRdBull = 2'd0;
      oRdCow  = 2'd0;
    end
  end

  assign oTries     = r_tries;
  assign oResultVld = r_result_vld;
  assign oReject    = r_reject;
  assign oWin       = r_win;
  assign oLose      = r_lose;
  assign oBusy      = r_busy;

endmodule

// File: tb/tb_bc_judge.sv
// tb_bc_judge: directed game sequence with randomized guesses, checked against
// a behavioural model of the game (secret drawn from the LFSR sequence, bulls/cows
// counted arithmetically, history kept in arrays).
module tb_bc_judge;

  localparam int          MAX_TRIES = 8;
  localparam logic [15:0] SEED      = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  iNum1 = 4'd0, iNum2 = 4'd0, iNum3 = 4'd0;
  logic        iNumRdy = 1'b0;
  logic        iNewGame = 1'b0;
  logic [2:0]  iRdAddr = 3'd0;
  logic [11:0] oRdNum;
  logic [1:0]  oRdBull, oRdCow;
  logic [3:0]  oTries;
  logic        oResultVld, oReject, oWin, oLose, oBusy;
`ifdef BC_DEBUG_EN
  logic [11:0] oSecret;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [15:0] m_lfsr;
  logic [3:0]  sec [3];
  logic [11:0] h_num [8];
  int          h_bull [8];
  int          h_cow  [8];
  int          m_tries;
  bit          m_win, m_lose;
  int          m_vld_total;
  int          vld_total = 0;
  logic [3:0]  dj [3];
  int          nd;

  bc_judge #(.MAX_TRIES(MAX_TRIES), .LFSR_SEED(SEED)) dut (
    .clk        (clk),
    .reset      (reset),
    .iNum1      (iNum1),
    .iNum2      (iNum2),
    .iNum3      (iNum3),
    .iNumRdy    (iNumRdy),
    .iNewGame   (iNewGame),
    .iRdAddr    (iRdAddr),
`ifdef BC_DEBUG_EN
    .iForceSecret (12'd0),
    .iForceLd     (1'b0),
    .oSecret      (oSecret),
`endif
    .oRdNum     (oRdNum),
    .oRdBull    (oRdBull),
    .oRdCow     (oRdCow),
    .oTries     (oTries),
    .oResultVld (oResultVld),
    .oReject    (oReject),
    .oWin       (oWin),
    .oLose      (oLose),
    .oBusy      (oBusy)
  );

  always #10 clk = ~clk;

  function automatic logic [15:0] step(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // The LFSR runs free every cycle, so the model tracks it in lockstep.
  always @(posedge clk) begin
    if (reset === 1'b1) m_lfsr <= SEED;
    else                m_lfsr <= step(m_lfsr);
  end

  always @(negedge clk) begin
    if (oResultVld === 1'b1) vld_total <= vld_total + 1;
  end

  function automatic bit valid3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    return (a < 4'd10) && (b < 4'd10) && (c < 4'd10) && (a != b) && (a != c) && (b != c);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model;
    m_tries = 0;
    m_win   = 1'b0;
    m_lose  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      h_num[i] = 12'd0; h_bull[i] = 0; h_cow[i] = 0;
    end
  endtask

  // Called just after the edge that put the DUT into GEN.
  task automatic wait_secret(input string tag);
    logic [15:0] l;
    int          k;
    bit          found;
    l = m_lfsr; k = 0; found = 1'b0;
    for (int n = 0; n < 70000 && !found; n++) begin
      if (valid3(l[11:8], l[7:4], l[3:0])) begin
        found = 1'b1; k = n;
        sec[0] = l[11:8]; sec[1] = l[7:4]; sec[2] = l[3:0];
      end else begin
        l = step(l);
      end
    end
    if (!found) begin
      n_fail++;
      $display("FAIL %s: model found no acceptable secret", tag);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "no secret");
    end
    for (int i = 0; i < k; i++) tick;
    check($sformatf("%s busy before accept", tag), 32'(oBusy), 32'd1);
    tick;
    check($sformatf("%s busy after accept", tag), 32'(oBusy), 32'd0);
`ifdef BC_DEBUG_EN
    check($sformatf("%s secret", tag), 32'(oSecret), 32'({sec[0], sec[1], sec[2]}));
`endif
  endtask

  task automatic run_guess(input string tag, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    int vld_at, rej_at, vld_cnt, rej_cnt, tries_at_vld, eb, ec;
    bit play;
    logic [3:0] g [3];
    g[0] = a; g[1] = b; g[2] = c;
    play = !m_win && !m_lose;
    iNum1 = a; iNum2 = b; iNum3 = c; iNumRdy = 1'b1;
    tick;
    iNumRdy = 1'b0;
    vld_at = 0; rej_at = 0; vld_cnt = 0; rej_cnt = 0; tries_at_vld = -1;
    for (int i = 1; i <= 5; i++) begin
      tick;
      if (oResultVld === 1'b1) begin
        vld_cnt++;
        if (vld_at == 0) begin vld_at = i; tries_at_vld = int'(oTries); end
      end
      if (oReject === 1'b1) begin
        rej_cnt++;
        if (rej_at == 0) rej_at = i;
      end
    end
    if (play && valid3(a, b, c)) begin
      eb = 0; ec = 0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          if (g[i] == sec[j]) begin
            if (i == j) eb++; else ec++;
          end
      h_num[m_tries] = {a, b, c}; h_bull[m_tries] = eb; h_cow[m_tries] = ec;
      m_tries++;
      m_vld_total++;
      if (eb == 3) m_win = 1'b1;
      else if (m_tries == MAX_TRIES) m_lose = 1'b1;
      check($sformatf("%s vld count", tag), 32'(vld_cnt), 32'd1);
      check($sformatf("%s vld latency", tag), 32'(vld_at), 32'd3);
      check($sformatf("%s tries at vld", tag), 32'(tries_at_vld), 32'(m_tries));
      check($sformatf("%s no reject", tag), 32'(rej_cnt), 32'd0);
    end else begin
      check($sformatf("%s no vld", tag), 32'(vld_cnt), 32'd0);
      check($sformatf("%s reject count", tag), 32'(rej_cnt), play ? 32'd1 : 32'd0);
      if (play) check($sformatf("%s reject latency", tag), 32'(rej_at), 32'd1);
    end
    check($sformatf("%s tries", tag), 32'(oTries), 32'(m_tries));
    check($sformatf("%s win", tag), 32'(oWin), 32'(m_win));
    check($sformatf("%s lose", tag), 32'(oLose), 32'(m_lose));
  endtask

  task automatic check_history(input string tag);
    for (int a = 0; a < 8; a++) begin
      iRdAddr = 3'(a);
      #1;
      check($sformatf("%s num[%0d]", tag, a), 32'(oRdNum), 32'(h_num[a]));
      check($sformatf("%s bull[%0d]", tag, a), 32'(oRdBull), 32'(h_bull[a]));
      check($sformatf("%s cow[%0d]", tag, a), 32'(oRdCow), 32'(h_cow[a]));
    end
    iRdAddr = 3'd0;
  endtask

  task automatic pick_disjoint;
    nd = 0;
    for (int v = 0; v < 10; v++) begin
      if (4'(v) != sec[0] && 4'(v) != sec[1] && 4'(v) != sec[2] && nd < 3) begin
        dj[nd] = 4'(v); nd++;
      end
    end
  endtask

  initial begin
    clear_model();
    m_vld_total = 0;

    // power-up reset
    reset = 1'b1;
    tick; tick;
    check("reset busy", 32'(oBusy), 32'd1);
    check("reset tries", 32'(oTries), 32'd0);
    check("reset win", 32'(oWin), 32'd0);
    check("reset lose", 32'(oLose), 32'd0);
    check("reset vld", 32'(oResultVld), 32'd0);
    check("reset reject", 32'(oReject), 32'd0);
    reset = 1'b0;
    wait_secret("g1");

    // game 1: reversed secret, rejects, random guesses, then win
    run_guess("g1 reversed", sec[2], sec[1], sec[0]);
    run_guess("g1 dup", 4'd4, 4'd5, 4'd5);
    run_guess("g1 nonbcd", 4'd9, 4'd10, 4'd0);
    for (int i = 0; i < 5; i++)
      run_guess($sformatf("g1 rnd%0d", i), 4'($urandom_range(0, 10)),
                4'($urandom_range(0, 10)), 4'($urandom_range(0, 10)));
    check_history("g1 hist");
    run_guess("g1 exact", sec[0], sec[1], sec[2]);
    run_guess("g1 after win", sec[2], sec[0], sec[1]);
    check_history("g1 final hist");

    // game 2: eight misses lose the game
    iNewGame = 1'b1; tick; iNewGame = 1'b0;
    clear_model();
    check("g2 newgame tries", 32'(oTries), 32'd0);
    check("g2 newgame win", 32'(oWin), 32'd0);
    wait_secret("g2");
    pick_disjoint();
    for (int i = 0; i < MAX_TRIES; i++)
      run_guess($sformatf("g2 miss%0d", i), dj[0], dj[1], dj[2]);
    check_history("g2 hist");
    run_guess("g2 after lose", sec[0], sec[1], sec[2]);

    // game 3: abort in flight, then iNewGame together with iNumRdy
    iNewGame = 1'b1; tick; iNewGame = 1'b0;
    clear_model();
    wait_secret("g3");
    for (int i = 0; i < 2; i++)
      run_guess($sformatf("g3 rnd%0d", i), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)));
    pick_disjoint();
    iNum1 = dj[0]; iNum2 = dj[1]; iNum3 = dj[2]; iNumRdy = 1'b1;
    tick;
    iNumRdy = 1'b0;
    tick;
    iNewGame = 1'b1; tick; iNewGame = 1'b0;
    clear_model();
    check("g3 abort tries", 32'(oTries), 32'd0);
    wait_secret("g4");
    pick_disjoint();
    run_guess("g4 first", dj[0], dj[1], dj[2]);
    iNum1 = sec[0]; iNum2 = sec[1]; iNum3 = sec[2];
    iNumRdy = 1'b1; iNewGame = 1'b1;
    tick;
    iNumRdy = 1'b0; iNewGame = 1'b0;
    clear_model();
    check("g4 same-cycle tries", 32'(oTries), 32'd0);
    check("g4 same-cycle busy", 32'(oBusy), 32'd1);
    check_history("g4 cleared hist");
    wait_secret("g5");

    // mid-game reset behaves like power-up
    run_guess("g5 rev", sec[2], sec[1], sec[0]);
    reset = 1'b1; tick; reset = 1'b0;
    clear_model();
    check("mid reset tries", 32'(oTries), 32'd0);
    check("mid reset busy", 32'(oBusy), 32'd1);
    check_history("mid reset hist");
    wait_secret("g6");
    run_guess("g6 rev", sec[2], sec[1], sec[0]);
    tick;
    check("total vld pulses", 32'(vld_total), 32'(m_vld_total));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
